// File: rtl/fir_seq_pkg.sv
// fir_seq_pkg: state encoding and default timing constants shared by the FIR sequencer files.
package fir_seq_pkg;
    localparam int NB_STATE = 3;
    localparam logic [NB_STATE-1:0] ST_IDLE  = 3'd0;
    localparam logic [NB_STATE-1:0] ST_FILL  = 3'd1;
    localparam logic [NB_STATE-1:0] ST_RUN   = 3'd2;
    localparam logic [NB_STATE-1:0] ST_DRAIN = 3'd3;
    localparam logic [NB_STATE-1:0] ST_DONE  = 3'd4;
    localparam int NB_PHASE_DEFAULT  = 2;
    localparam int OS_DEFAULT        = 2 ** NB_PHASE_DEFAULT;
    localparam int FILL_SYMS_DEFAULT = 2;
endpackage

// File: rtl/fir_phase_counter.sv
// fir_phase_counter: polyphase index counter; o_wrap marks the last phase of a symbol period.
module fir_phase_counter #(
    parameter int NB_PHASE = 2
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_clear,
    output logic [NB_PHASE-1:0] o_phase,
    output logic                o_wrap
);
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)
            o_phase <= '0;
        else if (i_clear)
            o_phase <= '0;
        else if (i_enable)
            o_phase <= o_phase + NB_PHASE'(1);
    end

    assign o_wrap = &o_phase;
endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: burst controller for the polyphase FIR (symbol strobe, phase, enable, fill/flush gating).
// Define FIR_SEQ_STATS_EN to add the o_sample_cnt valid-sample counter.
module fir_sequencer
    import fir_seq_pkg::*;
#(
    parameter int NB_PHASE  = NB_PHASE_DEFAULT,
    parameter int FILL_SYMS = FILL_SYMS_DEFAULT,
    parameter int NB_NSYM   = 16
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic                i_enable,
    input  logic                i_start,
    input  logic                i_stop,
    input  logic [NB_NSYM-1:0]  i_nsym,
    output logic                o_sym_valid,
    output logic                o_zero_fill,
    output logic [NB_PHASE-1:0] o_phase,
    output logic                o_fir_enable,
    output logic                o_out_valid,
    output logic                o_busy,
`ifdef FIR_SEQ_STATS_EN
    output logic [31:0]         o_sample_cnt,
`endif
    output logic                o_done
);
    localparam int NB_FILL = $clog2(FILL_SYMS + 1);
    localparam logic [NB_FILL-1:0] FILL_LAST = NB_FILL'(FILL_SYMS - 1);

    logic [NB_STATE-1:0] state, state_nxt;
    logic [NB_NSYM-1:0]  nsym_q, sym_cnt, sym_nxt;
    logic [NB_FILL-1:0]  fill_cnt;
    logic stop_flag, feeding, active, wrap, strobe, burst_end, start_ok;

    assign feeding   = (state == ST_FILL) || (state == ST_RUN);
    assign active    = feeding || (state == ST_DRAIN);
    assign start_ok  = i_enable && (state == ST_IDLE) && i_start;
    assign strobe    = i_enable && feeding && wrap;
    assign sym_nxt   = sym_cnt + NB_NSYM'(1);
    // a stop raised in the boundary cycle itself still ends the burst on that strobe
    assign burst_end = strobe && (stop_flag || i_stop || (nsym_q != '0 && sym_nxt == nsym_q));

    fir_phase_counter #(.NB_PHASE(NB_PHASE)) u_phase (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable && active),
        .i_clear  (i_enable && !active),
        .o_phase  (o_phase),
        .o_wrap   (wrap)
    );

    always_comb begin
        state_nxt = state;
        if (i_enable)
            case (state)
                ST_IDLE:  state_nxt = i_start ? ST_FILL : ST_IDLE;
                ST_FILL:  state_nxt = burst_end ? ST_DRAIN : (strobe && fill_cnt == FILL_LAST) ? ST_RUN : ST_FILL;
                ST_RUN:   state_nxt = burst_end ? ST_DRAIN : ST_RUN;
                ST_DRAIN: state_nxt = (wrap && fill_cnt == FILL_LAST) ? ST_DONE : ST_DRAIN;
                default:  state_nxt = ST_IDLE;
            endcase
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_IDLE;
            nsym_q    <= '0;
            sym_cnt   <= '0;
            fill_cnt  <= '0;
            stop_flag <= 1'b0;
        end else if (i_enable) begin
            state     <= state_nxt;
            stop_flag <= feeding && !wrap && (stop_flag || i_stop);
            if (start_ok) begin
                nsym_q   <= i_nsym;
                sym_cnt  <= '0;
                fill_cnt <= '0;
            end else begin
                if (strobe)
                    sym_cnt <= sym_nxt;
                // fill_cnt is reused to count flush symbols once DRAIN begins
                if (burst_end)
                    fill_cnt <= '0;
                else if ((state == ST_FILL || state == ST_DRAIN) && wrap)
                    fill_cnt <= fill_cnt + NB_FILL'(1);
            end
        end
    end

    assign o_sym_valid  = strobe;
    assign o_zero_fill  = state == ST_DRAIN;
    assign o_fir_enable = i_enable && active;
    assign o_out_valid  = i_enable && (state == ST_RUN || state == ST_DRAIN);
    assign o_busy       = state != ST_IDLE;
    assign o_done       = i_enable && (state == ST_DONE);

`ifdef FIR_SEQ_STATS_EN
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset)
            o_sample_cnt <= '0;
        else if (start_ok)
            o_sample_cnt <= '0;
        else if (o_out_valid && !(&o_sample_cnt))
            o_sample_cnt <= o_sample_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: randomized and directed bench for fir_sequencer against a burst-timeline model.
module tb_fir_sequencer;
    import fir_seq_pkg::*;

    localparam int OS   = OS_DEFAULT;
    localparam int FILL = FILL_SYMS_DEFAULT;
    localparam int BIG  = 1 << 24;

    logic        clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [15:0] i_nsym = '0;
    logic        o_sym_valid, o_zero_fill, o_fir_enable, o_out_valid, o_busy, o_done;
    logic [1:0]  o_phase;
`ifdef FIR_SEQ_STATS_EN
    logic [31:0] o_sample_cnt;
`endif

    fir_sequencer dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .i_nsym       (i_nsym),
        .o_sym_valid  (o_sym_valid),
        .o_zero_fill  (o_zero_fill),
        .o_phase      (o_phase),
        .o_fir_enable (o_fir_enable),
        .o_out_valid  (o_out_valid),
        .o_busy       (o_busy),
`ifdef FIR_SEQ_STATS_EN
        .o_sample_cnt (o_sample_cnt),
`endif
        .o_done       (o_done)
    );

    always #5 clock = ~clock;

    // model: t is the number of enabled cycles since the burst was accepted (0 = idle),
    // s_lim the number of real symbols the burst will consume
    int t = 0;
    int s_lim = BIG;
    int smp = 0;
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0d time=%0t", tag, got, exp, t, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sym_valid"}, 32'(o_sym_valid), 32'd0);
        chk({tag, "_zero_fill"}, 32'(o_zero_fill), 32'd0);
        chk({tag, "_phase"}, 32'(o_phase), 32'd0);
        chk({tag, "_fir_enable"}, 32'(o_fir_enable), 32'd0);
        chk({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
`ifdef FIR_SEQ_STATS_EN
        chk({tag, "_sample_cnt"}, o_sample_cnt, 32'd0);
`endif
    endtask

    task automatic step(input logic en, input logic st, input logic sp, input logic [15:0] ns);
        int end_t, lo;
        logic feed, drn, dn, ov;
        i_enable = en;
        i_start  = st;
        i_stop   = sp;
        i_nsym   = ns;
        @(negedge clock);
        if (en && sp && t > 0 && t <= OS * s_lim && (t + OS - 1) / OS < s_lim)
            s_lim = (t + OS - 1) / OS;
        end_t = OS * (s_lim + FILL);
        lo    = OS * (s_lim < FILL ? s_lim : FILL);
        feed  = t > 0 && t <= OS * s_lim;
        drn   = t > OS * s_lim && t <= end_t;
        dn    = t == end_t + 1;
        ov    = en && t > lo && t <= end_t;
        chk("sym_valid", 32'(o_sym_valid), 32'(en && feed && (t % OS == 0)));
        chk("zero_fill", 32'(o_zero_fill), 32'(drn));
        chk("phase", 32'(o_phase), (feed || drn) ? 32'((t - 1) % OS) : 32'd0);
        chk("fir_enable", 32'(o_fir_enable), 32'(en && (feed || drn)));
        chk("out_valid", 32'(o_out_valid), 32'(ov));
        chk("busy", 32'(o_busy), 32'(t != 0));
        chk("done", 32'(o_done), 32'(en && dn));
`ifdef FIR_SEQ_STATS_EN
        chk("sample_cnt", o_sample_cnt, 32'(smp));
`endif
        @(posedge clock);
        if (en) begin
            if (t == 0) begin
                if (st) begin
                    t = 1;
                    s_lim = (ns != 0) ? int'(ns) : BIG;
                    smp = 0;
                end
            end else if (dn)
                t = 0;
            else
                t++;
            if (ov)
                smp++;
        end
        #1;
    endtask

    task automatic finish_burst();
        for (int k = 0; k < 200 && t != 0; k++)
            step(1'b1, 1'b0, 1'b0, 16'd0);
        chk("burst_ended", 32'(o_busy), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_all_zero("reset");
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        // nominal burst of 5 symbols
        step(1'b1, 1'b1, 1'b0, 16'd5);
        finish_burst();
        repeat (2) step(1'b1, 1'b0, 1'b0, 16'd0);
        // single-symbol burst: FILL straight to DRAIN
        step(1'b1, 1'b1, 1'b0, 16'd1);
        finish_burst();
        // continuous mode, stop in cycle 30
        step(1'b1, 1'b1, 1'b0, 16'd0);
        for (int k = 1; k <= 40; k++)
            step(1'b1, 1'b0, k == 30, 16'd0);
        finish_burst();
        // enable low for 7 cycles at phase 2 of RUN
        step(1'b1, 1'b1, 1'b0, 16'd6);
        for (int k = 1; k <= 14; k++)
            step(1'b1, 1'b0, 1'b0, 16'd0);
        repeat (7) step(1'b0, 1'b0, 1'b1, 16'd0);
        finish_burst();
        // reset while in DRAIN
        step(1'b1, 1'b1, 1'b0, 16'd3);
        for (int k = 1; k <= 14; k++)
            step(1'b1, 1'b0, 1'b0, 16'd0);
        chk("pre_reset_drain", 32'(o_zero_fill), 32'd1);
        i_reset = 1'b0;
        #1;
        chk_all_zero("async_reset");
        t = 0;
        smp = 0;
        @(negedge clock);
        i_reset = 1'b1;
        @(posedge clock);
        #1;
        repeat (12) step(1'b1, 1'b0, 1'b0, 16'd0);
        // start while busy ignored; start with stop in IDLE begins a burst
        step(1'b1, 1'b1, 1'b0, 16'd4);
        for (int k = 1; k <= 6; k++)
            step(1'b1, k == 6, 1'b0, 16'd9);
        finish_burst();
        step(1'b1, 1'b1, 1'b1, 16'd3);
        finish_burst();
        // randomized bursts
        for (int b = 0; b < 14; b++) begin
            step(1'b1, 1'b1, $urandom_range(0, 3) == 0, 16'($urandom_range(0, 7)));
            for (int k = 0; k < 200 && t != 0; k++)
                step($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                     k > 60 || $urandom_range(0, 39) == 0, 16'($urandom_range(0, 7)));
            chk("rand_burst_ended", 32'(o_busy), 32'd0);
            repeat ($urandom_range(1, 3)) step($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1, 16'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fir_sequencer.md
Name: fir_sequencer

Overview:
- Controller that sequences the polyphase FIR datapath for one burst of symbols.
- Generates the symbol-rate input strobe, the polyphase index and the FIR enable.
- Gates output-valid during the filter fill, then flushes the filter with zero symbols after the last real symbol.
- Sits between the bit source and filtro_fir, replacing the free-running control counter.

Parameters:
- NB_PHASE, 2, width of phase index; oversampling factor OS = 2**NB_PHASE.
- FILL_SYMS, 2, symbol periods needed to fill or flush the filter (ceil(taps/OS)).
- NB_NSYM, 16, width of the burst-length input and symbol counter.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  global enable; low freezes all state.
- i_start  in  1  single-cycle burst start request.
- i_stop  in  1  request to end the burst early.
- i_nsym  in  NB_NSYM  burst length in symbols, sampled on start; 0 means continuous.
- o_sym_valid  out  1  one-cycle strobe to consume the next input symbol.
- o_zero_fill  out  1  high during DRAIN; datapath muxes zero symbols into the FIR.
- o_phase  out  NB_PHASE  current polyphase index.
- o_fir_enable  out  1  FIR enable.
- o_out_valid  out  1  FIR output sample is valid this cycle.
- o_busy  out  1  state is not IDLE.
- o_done  out  1  one-cycle pulse at burst end.

Behaviour:
- Reset (async, i_reset=0): state IDLE, phase 0, all counters 0, all outputs 0.
- States: IDLE, FILL, RUN, DRAIN, DONE. Encoding is binary.
- Phase counter: counts 0..OS-1 and wraps, only in FILL, RUN and DRAIN. It is held at 0 otherwise. o_phase equals the counter.
- Symbol boundary: a cycle where phase == OS-1.
- IDLE:
  - i_start=1 and i_enable=1 -> FILL.
  - Latch i_nsym; clear sym_cnt and fill_cnt.
  - i_stop is ignored in IDLE, so start wins if both are high.
- o_sym_valid: equals (state is FILL or RUN) and boundary.
  - Start sampled at edge 0 -> strobes visible in cycles OS, 2*OS, ... after that edge.
  - Each strobe increments sym_cnt.
- FILL: o_fir_enable=1, o_out_valid=0.
  - On the FILL_SYMS-th strobe -> RUN.
  - If the burst ends first (see end condition) -> DRAIN.
- RUN: o_fir_enable=1, o_out_valid=1 every cycle.
- End condition: evaluated on a strobe. Either sym_cnt+1 == latched nsym (nsym != 0), or i_stop has been seen since the last boundary (sticky stop flag). Result -> DRAIN.
- DRAIN: o_zero_fill=1, o_sym_valid=0, o_fir_enable=1, o_out_valid=1.
  - Lasts exactly FILL_SYMS symbol periods (FILL_SYMS*OS cycles), then -> DONE.
- DONE: o_done=1 for one cycle, then -> IDLE. o_out_valid=0.
- i_start while busy: ignored.
- i_stop in DRAIN or DONE: ignored.
- i_enable=0 in any state:
  - State, phase and counters hold.
  - o_sym_valid, o_out_valid, o_fir_enable and o_done are forced to 0.
  - o_phase, o_busy and o_zero_fill hold their values.
  - Resumes exactly where it stopped.
- Reset mid-burst: immediate return to IDLE, no o_done pulse.
- Continuous mode (nsym=0): sym_cnt wraps modulo 2**NB_NSYM with no effect; only i_stop ends the burst.

Optional Feature:
- Macro: FIR_SEQ_STATS_EN.
- Defined: adds output o_sample_cnt (32 bits).
  - Counts cycles with o_out_valid=1.
  - Cleared on reset and on accepted start; saturates at all-ones.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fir_seq_pkg holds:
  - state encoding localparams (ST_IDLE=0, ST_FILL=1, ST_RUN=2, ST_DRAIN=3, ST_DONE=4);
  - default OS and FILL_SYMS constants.
- One sub-module, fir_phase_counter:
  - enable/clear inputs;
  - NB_PHASE-bit wrap counter;
  - o_wrap output that serves as the boundary.

Test Plan:
- Reset, then start with nsym=5, OS=4 -> o_sym_valid in cycles 4,8,12,16,20.
  - o_out_valid rises the cycle after the 2nd strobe.
  - DRAIN lasts 8 cycles; o_done pulses once; o_busy low 10 cycles after the last strobe.
- nsym=1 -> FILL goes directly to DRAIN after one strobe; no RUN state visited; exactly 1 strobe.
- nsym=0, i_stop pulsed in cycle 30 -> strobes continue up to the boundary at cycle 32, then DRAIN; 8 strobes total.
- i_enable low for 7 cycles mid-RUN at phase 2 -> outputs gated; on resume phase continues 2,3 and the next strobe is delayed by 7 cycles.
- i_reset asserted in DRAIN -> all outputs 0 immediately; no o_done.
- i_start while busy and start/stop simultaneous in IDLE -> busy start ignored; simultaneous pair begins a burst.
